// File: rtl/lane_dup_pkg.sv
// Shared types and helpers for the lane duplicator: lane-index width,
// the full-size mask record and a saturating 32-bit add.
package lane_dup_pkg;

    localparam int MAX_ELEMENTS = 32;
    localparam int MAX_IDX_W    = 5;

    function automatic int idx_w(input int num_elements);
        return (num_elements > 1) ? $clog2(num_elements) : 1;
    endfunction

    // Mask record sized for the widest supported beat; narrower builds use the low lanes.
    typedef struct packed {
        logic [MAX_ELEMENTS-1:0]                dup;
        logic [MAX_ELEMENTS-1:0][MAX_IDX_W-1:0] orig;
    } mask_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/lane_duplicate_seq_if.sv
// Mask, input-stream and output-stream handshakes of the lane duplicator.
// master = traffic source/sink, slave = the duplicator.
interface lane_duplicate_seq_if #(
    parameter int DATA_W       = 32,
    parameter int NUM_ELEMENTS = 8
);
    import lane_dup_pkg::*;

    localparam int IDX_W = idx_w(NUM_ELEMENTS);

    logic                           mask_valid;
    logic                           mask_ready;
    logic [NUM_ELEMENTS-1:0]        mask_dup;
    logic [NUM_ELEMENTS*IDX_W-1:0]  mask_orig;

    logic                           in_valid;
    logic                           in_ready;
    logic [NUM_ELEMENTS*DATA_W-1:0] in_data;
    logic [NUM_ELEMENTS-1:0]        in_keep;
    logic                           in_last;

    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_ELEMENTS*DATA_W-1:0] out_data;
    logic [NUM_ELEMENTS-1:0]        out_keep;
    logic                           out_last;

    modport master (
        output mask_valid, mask_dup, mask_orig,
        output in_valid, in_data, in_keep, in_last,
        output out_ready,
        input  mask_ready, in_ready,
        input  out_valid, out_data, out_keep, out_last
    );

    modport slave (
        input  mask_valid, mask_dup, mask_orig,
        input  in_valid, in_data, in_keep, in_last,
        input  out_ready,
        output mask_ready, in_ready,
        output out_valid, out_data, out_keep, out_last
    );

endinterface

// File: rtl/lane_dup_mask_fifo.sv
// Mask FIFO: head entry is read straight from storage, so a pushed mask
// becomes visible one cycle later (no fall-through). Reports occupancy.
module lane_dup_mask_fifo #(
    parameter  int W     = 32,
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [W-1:0]     head_data,
    output logic [LVL_W-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Full refuses a push even if the head pops in the same cycle.
    assign push_ready = rst_n && (level_q < LVL_W'(DEPTH));
    assign head_valid = (level_q != '0);
    assign head_data  = mem_q[rd_ptr_q];
    assign level      = level_q;
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && head_valid;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/lane_duplicate_seq.sv
// Lane duplicator: each output lane is either its own input lane or a copy of
// another input lane chosen by the head mask. Counters built with LANE_DUPLICATE_STATS_EN.
module lane_duplicate_seq
    import lane_dup_pkg::*;
#(
    parameter  int DATA_W       = 32,
    parameter  int NUM_ELEMENTS = 8,
    parameter  int MASK_DEPTH   = 4,
    parameter  int PER_PACKET   = 0,
    localparam int IDX_W        = idx_w(NUM_ELEMENTS),
    localparam int LVL_W        = $clog2(MASK_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    lane_duplicate_seq_if.slave bus,
    output logic [LVL_W-1:0]    mask_level,
    output logic                err_origin,
    output logic [31:0]         stat_beats,
    output logic [31:0]         stat_dups
);
    localparam int MASK_W = NUM_ELEMENTS * (IDX_W + 1);

    logic                           head_valid;
    logic [MASK_W-1:0]              head_flat;
    logic [NUM_ELEMENTS-1:0]        head_dup;
    logic [NUM_ELEMENTS*IDX_W-1:0]  head_orig;
    logic                           in_ready;
    logic                           accept;
    logic                           pop;
    logic [NUM_ELEMENTS*DATA_W-1:0] dup_data;
    logic [NUM_ELEMENTS-1:0]        dup_keep;
    logic                           orig_err;
    logic [IDX_W-1:0]               src;

    logic                           out_valid_q, out_valid_d;
    logic                           out_last_q, out_last_d;
    logic                           err_q, err_d;
    logic [NUM_ELEMENTS*DATA_W-1:0] out_data_q, out_data_d;
    logic [NUM_ELEMENTS-1:0]        out_keep_q, out_keep_d;

    lane_dup_mask_fifo #(
        .W     (MASK_W),
        .DEPTH (MASK_DEPTH)
    ) u_mask_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (bus.mask_valid),
        .push_ready (bus.mask_ready),
        .push_data  ({bus.mask_orig, bus.mask_dup}),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_flat),
        .level      (mask_level)
    );

    assign {head_orig, head_dup} = head_flat;

    assign in_ready     = rst_n && head_valid && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = in_ready;
    assign accept       = bus.in_valid && in_ready;
    // In packet mode the head mask stays put until the last beat of the packet.
    assign pop          = accept && ((PER_PACKET == 0) || bus.in_last);

    // Sources always come from the raw input beat, so chained origins never cascade.
    always_comb begin
        dup_data = bus.in_data;
        dup_keep = bus.in_keep;
        orig_err = 1'b0;
        src      = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            src = head_orig[i*IDX_W +: IDX_W];
            if (head_dup[i]) begin
                dup_data[i*DATA_W +: DATA_W] = bus.in_data[int'(src)*DATA_W +: DATA_W];
                dup_keep[i]                  = 1'b1;
                if (!bus.in_keep[src]) begin
                    orig_err = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        err_d       = err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_last_d  = bus.in_last;
            out_data_d  = dup_data;
            out_keep_d  = dup_keep;
            err_d       = err_q | orig_err;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        out_data_q <= out_data_d;
        out_keep_q <= out_keep_d;
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_keep  = out_keep_q;
    assign err_origin    = err_q;

`ifdef LANE_DUPLICATE_STATS_EN
    logic [31:0] dup_cnt;
    logic [31:0] stat_beats_q, stat_beats_d;
    logic [31:0] stat_dups_q, stat_dups_d;

    always_comb begin
        dup_cnt = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            dup_cnt = dup_cnt + {31'd0, head_dup[i]};
        end
        stat_beats_d = stat_beats_q;
        stat_dups_d  = stat_dups_q;
        if (accept) begin
            stat_beats_d = sat_add32(stat_beats_q, 32'd1);
            stat_dups_d  = sat_add32(stat_dups_q, dup_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_beats_q <= '0;
            stat_dups_q  <= '0;
        end else begin
            stat_beats_q <= stat_beats_d;
            stat_dups_q  <= stat_dups_d;
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_dups  = stat_dups_q;
`else
    assign stat_beats = '0;
    assign stat_dups  = '0;
`endif

endmodule

// File: tb/tb_lane_duplicate_seq.sv
// Bench for lane_duplicate_seq: directed scenarios plus random traffic on a
// per-beat instance and a per-packet instance, checked against a queue model.
module tb_lane_duplicate_seq;
    import lane_dup_pkg::*;

    localparam int DW    = 8;
    localparam int N     = 8;
    localparam int IW    = 3;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lane_duplicate_seq_if #(.DATA_W(DW), .NUM_ELEMENTS(N)) bus0 ();
    lane_duplicate_seq_if #(.DATA_W(DW), .NUM_ELEMENTS(N)) bus1 ();

    logic [LW-1:0] lvl0, lvl1;
    logic          err0, err1;
    logic [31:0]   sb0, sd0, sb1, sd1;

    lane_duplicate_seq #(.DATA_W(DW), .NUM_ELEMENTS(N), .MASK_DEPTH(DEPTH), .PER_PACKET(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .mask_level(lvl0),
        .err_origin(err0), .stat_beats(sb0), .stat_dups(sd0));

    lane_duplicate_seq #(.DATA_W(DW), .NUM_ELEMENTS(N), .MASK_DEPTH(DEPTH), .PER_PACKET(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .mask_level(lvl1),
        .err_origin(err1), .stat_beats(sb1), .stat_dups(sd1));

    // Active instance: 0 = one mask per beat, 1 = one mask per packet.
    int cur = 0;

    logic          s_ov, s_olast, s_mrdy, s_irdy, s_err;
    logic [N*DW-1:0] s_odata;
    logic [N-1:0]  s_okeep;
    logic [LW-1:0] s_lvl;
    logic [31:0]   s_sb, s_sd;

    assign s_ov    = (cur == 0) ? bus0.out_valid  : bus1.out_valid;
    assign s_olast = (cur == 0) ? bus0.out_last   : bus1.out_last;
    assign s_odata = (cur == 0) ? bus0.out_data   : bus1.out_data;
    assign s_okeep = (cur == 0) ? bus0.out_keep   : bus1.out_keep;
    assign s_mrdy  = (cur == 0) ? bus0.mask_ready : bus1.mask_ready;
    assign s_irdy  = (cur == 0) ? bus0.in_ready   : bus1.in_ready;
    assign s_lvl   = (cur == 0) ? lvl0 : lvl1;
    assign s_err   = (cur == 0) ? err0 : err1;
    assign s_sb    = (cur == 0) ? sb0  : sb1;
    assign s_sd    = (cur == 0) ? sd0  : sd1;

    // Stimulus for the next clock edge.
    logic            nx_mv, nx_iv, nx_last, nx_ordy;
    logic [N-1:0]    nx_dup, nx_keep;
    logic [N*IW-1:0] nx_orig;
    logic [N*DW-1:0] nx_data;

    // Reference model state.
    mask_t           mq[$];
    bit              exp_ov;
    logic [N*DW-1:0] exp_data;
    logic [N-1:0]    exp_keep;
    bit              exp_last;
    bit              exp_err;
    logic [31:0]     exp_beats, exp_dups;

    int checks   = 0;
    int failures = 0;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t inst=%0d)", tag, act, exp, $time, cur);
        end
    endtask

    task automatic drive();
        bus0.mask_valid = (cur == 0) && nx_mv;
        bus0.mask_dup   = nx_dup;
        bus0.mask_orig  = nx_orig;
        bus0.in_valid   = (cur == 0) && nx_iv;
        bus0.in_data    = nx_data;
        bus0.in_keep    = nx_keep;
        bus0.in_last    = nx_last;
        bus0.out_ready  = (cur == 0) ? nx_ordy : 1'b1;
        bus1.mask_valid = (cur == 1) && nx_mv;
        bus1.mask_dup   = nx_dup;
        bus1.mask_orig  = nx_orig;
        bus1.in_valid   = (cur == 1) && nx_iv;
        bus1.in_data    = nx_data;
        bus1.in_keep    = nx_keep;
        bus1.in_last    = nx_last;
        bus1.out_ready  = (cur == 1) ? nx_ordy : 1'b1;
    endtask

    task automatic idle_stim();
        nx_mv = 0; nx_iv = 0; nx_last = 0; nx_ordy = 1;
        nx_dup = '0; nx_keep = '0; nx_orig = '0; nx_data = '0;
    endtask

    task automatic check_outputs();
        chk_eq("out_valid", s_ov, exp_ov);
        if (exp_ov) begin
            chk_eq("out_data", s_odata, exp_data);
            chk_eq("out_keep", s_okeep, exp_keep);
            chk_eq("out_last", s_olast, exp_last);
        end
        chk_eq("mask_level", s_lvl, mq.size());
        chk_eq("mask_ready", s_mrdy, mq.size() < DEPTH);
        chk_eq("err_origin", s_err, exp_err);
`ifdef LANE_DUPLICATE_STATS_EN
        chk_eq("stat_beats", s_sb, exp_beats);
        chk_eq("stat_dups", s_sd, exp_dups);
`else
        chk_eq("stat_beats", s_sb, 0);
        chk_eq("stat_dups", s_sd, 0);
`endif
    endtask

    // Applies the rules for one clock edge given the stimulus in nx_*.
    task automatic model_step();
        bit          mrdy, irdy;
        mask_t       m, nm;
        int          src;
        logic [63:0] d;
        mrdy = (mq.size() < DEPTH);
        irdy = (mq.size() > 0) && (!exp_ov || nx_ordy);
        chk_eq("in_ready", s_irdy, irdy);
        if (exp_ov && nx_ordy) exp_ov = 0;
        if (nx_iv && irdy) begin
            m = mq[0];
            for (int i = 0; i < N; i++) begin
                if (m.dup[i]) begin
                    src = int'(m.orig[i]);
                    exp_data[i*DW +: DW] = nx_data[src*DW +: DW];
                    exp_keep[i] = 1'b1;
                    if (!nx_keep[src]) exp_err = 1;
                    d = 64'(exp_dups) + 64'd1;
                    exp_dups = (d > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : d[31:0];
                end else begin
                    exp_data[i*DW +: DW] = nx_data[i*DW +: DW];
                    exp_keep[i] = nx_keep[i];
                end
            end
            exp_ov   = 1;
            exp_last = nx_last;
            if (exp_beats != 32'hFFFF_FFFF) exp_beats = exp_beats + 1;
            if (cur == 0 || nx_last) void'(mq.pop_front());
        end
        if (nx_mv && mrdy) begin
            nm = '0;
            nm.dup[N-1:0] = nx_dup;
            for (int i = 0; i < N; i++) nm.orig[i] = MAX_IDX_W'(nx_orig[i*IW +: IW]);
            mq.push_back(nm);
        end
    endtask

    // Drive at a falling edge, let one rising edge act, check at the next falling edge.
    task automatic cycle();
        drive();
        #1;
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_stim();
        drive();
        #1;
        chk_eq("rst_out_valid", s_ov, 0);
        chk_eq("rst_out_last", s_olast, 0);
        chk_eq("rst_mask_level", s_lvl, 0);
        chk_eq("rst_err_origin", s_err, 0);
        chk_eq("rst_mask_ready", s_mrdy, 0);
        chk_eq("rst_in_ready", s_irdy, 0);
        chk_eq("rst_stat_beats", s_sb, 0);
        chk_eq("rst_stat_dups", s_sd, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        exp_ov = 0; exp_last = 0; exp_err = 0;
        exp_beats = '0; exp_dups = '0;
        exp_data = '0; exp_keep = '0;
    endtask

    function automatic logic [N*IW-1:0] ident_orig();
        logic [N*IW-1:0] o;
        for (int i = 0; i < N; i++) o[i*IW +: IW] = IW'(i);
        return o;
    endfunction

    function automatic logic [N*DW-1:0] ramp(input logic [7:0] base);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = base + 8'(i);
        return v;
    endfunction

    task automatic push_mask(input logic [N-1:0] dup, input logic [N*IW-1:0] orig);
        idle_stim();
        nx_mv = 1; nx_dup = dup; nx_orig = orig;
        cycle();
    endtask

    task automatic send_beat(input logic [N*DW-1:0] data, input logic [N-1:0] keep, input logic last);
        idle_stim();
        nx_iv = 1; nx_data = data; nx_keep = keep; nx_last = last;
        cycle();
    endtask

    task automatic rand_stim();
        nx_mv   = ($urandom_range(0, 99) < 50);
        nx_dup  = N'($urandom);
        nx_orig = (N*IW)'($urandom);
        nx_iv   = ($urandom_range(0, 99) < 70);
        nx_data = {$urandom, $urandom};
        nx_keep = N'($urandom);
        nx_last = ($urandom_range(0, 99) < 30);
        nx_ordy = ($urandom_range(0, 99) < 80);
    endtask

    logic [N*IW-1:0] o;
    logic [N*DW-1:0] held;

    initial begin
        idle_stim();
        drive();
        @(negedge clk);
        cur = 0;
        do_reset();

        // Single duplicate: lane1 <- lane0, keep upgrades to 0x03.
        o = ident_orig(); o[1*IW +: IW] = 3'd0;
        push_mask(8'h02, o);
        send_beat(ramp(8'hA0), 8'h01, 1'b0);
        chk_eq("dup_lane1", s_odata[15:8], 8'hA0);
        chk_eq("dup_keep", s_okeep, 8'h03);
        idle_stim(); cycle();

        // Chained origins take raw input lanes.
        o = ident_orig(); o[1*IW +: IW] = 3'd0; o[2*IW +: IW] = 3'd1;
        push_mask(8'h06, o);
        send_beat(ramp(8'h10), 8'hFF, 1'b1);
        chk_eq("chain_lane1", s_odata[15:8], 8'h10);
        chk_eq("chain_lane2", s_odata[23:16], 8'h11);
        idle_stim(); cycle();

        // Fill the FIFO, then push+pop while full.
        for (int k = 0; k < DEPTH; k++) push_mask(N'(k), ident_orig());
        chk_eq("full_level", s_lvl, 4);
        chk_eq("full_mask_ready", s_mrdy, 0);
        idle_stim();
        nx_mv = 1; nx_dup = 8'hFF; nx_orig = '0;
        nx_iv = 1; nx_data = ramp(8'h40); nx_keep = 8'hFF;
        cycle();
        chk_eq("full_pushpop_level", s_lvl, 3);
        for (int k = 0; k < 3; k++) send_beat(ramp(8'h50 + 8'(k*8)), 8'hF0, 1'b0);
        idle_stim(); cycle();

        // Output backpressure for five cycles.
        push_mask(8'h00, ident_orig());
        push_mask(8'h80, '0);
        send_beat(ramp(8'h60), 8'hFF, 1'b0);
        held = s_odata;
        idle_stim(); nx_ordy = 0; nx_iv = 1; nx_data = ramp(8'h70); nx_keep = 8'h0F;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk_eq("stall_hold", s_odata, held);
            chk_eq("stall_in_ready", s_irdy, 0);
        end
        nx_ordy = 1;
        cycle();
        chk_eq("release_lane7", s_odata[63:56], 8'h70);
        idle_stim(); cycle();

        // Origin lane without keep sets the sticky error.
        do_reset();
        o = ident_orig(); o[3*IW +: IW] = 3'd5;
        push_mask(8'h08, o);
        send_beat(ramp(8'h20), 8'hDF, 1'b0);
        chk_eq("err_set", s_err, 1);
        chk_eq("err_lane3", s_odata[31:24], 8'h25);
        chk_eq("err_keep", s_okeep, 8'hDF);
        for (int k = 0; k < 3; k++) begin
            idle_stim(); cycle();
            chk_eq("err_sticky", s_err, 1);
        end
`ifdef LANE_DUPLICATE_STATS_EN
        chk_eq("err_stat_dups", s_sd, 1);
`endif
        push_mask(8'h01, '0);
        push_mask(8'h03, '0);
        idle_stim(); nx_iv = 1; nx_ordy = 0; nx_data = ramp(8'h30); nx_keep = 8'hFF;
        cycle();
        do_reset();

        // Per-packet mask: three beats share one mask, fourth waits.
        cur = 1;
        do_reset();
        o = ident_orig(); o[0] = 1'b1;
        push_mask(8'h01, o);
        chk_eq("pkt_level_1", s_lvl, 1);
        send_beat(ramp(8'h80), 8'hFF, 1'b0);
        chk_eq("pkt_b1_lane0", s_odata[7:0], 8'h81);
        send_beat(ramp(8'h88), 8'hFF, 1'b0);
        chk_eq("pkt_b2_lane0", s_odata[7:0], 8'h89);
        chk_eq("pkt_level_mid", s_lvl, 1);
        send_beat(ramp(8'h90), 8'hFF, 1'b1);
        chk_eq("pkt_b3_lane0", s_odata[7:0], 8'h91);
        chk_eq("pkt_level_0", s_lvl, 0);
        for (int k = 0; k < 3; k++) begin
            send_beat(ramp(8'h98), 8'hFF, 1'b1);
            chk_eq("pkt_b4_stall", s_irdy, 0);
        end
        idle_stim(); nx_mv = 1; nx_dup = 8'h00; nx_orig = '0;
        nx_iv = 1; nx_data = ramp(8'h98); nx_keep = 8'hFF; nx_last = 1;
        cycle();
        send_beat(ramp(8'h98), 8'hFF, 1'b1);
        chk_eq("pkt_b4_lane0", s_odata[7:0], 8'h98);
        idle_stim(); cycle();

        // Random traffic on both configurations.
        for (int inst = 0; inst < 2; inst++) begin
            cur = inst;
            do_reset();
            for (int k = 0; k < 400; k++) begin
                rand_stim();
                cycle();
            end
            idle_stim();
            repeat (3) cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=%0d expected=finished", checks);
        $fatal(1, "bench timeout");
    end

endmodule
